nios2_mult_pipe_cell: RTL and testbench

Parametrised successor to the fixed 16x16 three-partial-product multiplier cell in the Nios II core. Produces the full 2*DATA_W product in-cell from SLICE_W x SLICE_W partial products, with per-operand signed/unsigned mode and high/low word select. Pipelined with valid tracking and a global stall enable. Serves mul/mulxss/mulxsu/mulxuu in the E->M->W path.

---
 rtl/nios2_mult_pipe_cell.sv | 162 ++++++++++++++++
 tb/tb_nios2_mult_pipe_cell.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/nios2_mult_pipe_cell.sv
// Pipelined DATA_W x DATA_W multiplier cell built from SLICE_W slice products, signed/unsigned per operand.
// Optional accumulator in the final stage is enabled by defining NIOS2_MULT_PIPE_ACC_EN.
module nios2_mult_pipe_cell #(
    parameter int DATA_W      = 32,
    parameter int SLICE_W     = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  M_en,
    input  logic                  E_valid,
    input  logic [DATA_W-1:0]     E_src1,
    input  logic [DATA_W-1:0]     E_src2,
    input  logic                  E_sign1,
    input  logic                  E_sign2,
    input  logic                  E_hi,
`ifdef NIOS2_MULT_PIPE_ACC_EN
    input  logic                  E_acc,
    input  logic                  E_acc_clr,
`endif
    output logic                  M_valid,
    output logic [DATA_W-1:0]     M_result,
    output logic [2*DATA_W-1:0]   M_product,
    output logic                  busy
);
    localparam int NS = DATA_W / SLICE_W;
    localparam int PW = 2 * DATA_W;
    localparam int SP = 2 * SLICE_W;

    typedef struct packed {
        logic          vld;
        logic          hi;
`ifdef NIOS2_MULT_PIPE_ACC_EN
        logic          acc;
        logic          clr;
`endif
        logic [PW-1:0] p;
    } stg_t;

    logic [NS*NS-1:0][SP-1:0] pp_q, pp_d;
    logic [DATA_W-1:0]        corr_q, corr_d;
    logic                     s1_vld_q, s1_hi_q;
`ifdef NIOS2_MULT_PIPE_ACC_EN
    logic                     s1_acc_q, s1_clr_q;
    logic [PW-1:0]            acc_q, acc_d;
`endif
    logic [PW-1:0]            sum;
    stg_t                     s2_d, fin;
    logic [PW-1:0]            fin_p;
    logic                     dly_busy;

    // Signed operands are handled as unsigned products minus (msb ? other : 0) << DATA_W, mod 2^PW.
    always_comb begin
        pp_d = '0;
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < NS; j++)
                pp_d[i*NS+j] = SP'(E_src1[i*SLICE_W +: SLICE_W]) * SP'(E_src2[j*SLICE_W +: SLICE_W]);
        corr_d = ((E_sign1 & E_src1[DATA_W-1]) ? E_src2 : '0)
               + ((E_sign2 & E_src2[DATA_W-1]) ? E_src1 : '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pp_q     <= '0;
            corr_q   <= '0;
            s1_vld_q <= 1'b0;
            s1_hi_q  <= 1'b0;
`ifdef NIOS2_MULT_PIPE_ACC_EN
            s1_acc_q <= 1'b0;
            s1_clr_q <= 1'b0;
`endif
        end else if (M_en) begin
            pp_q     <= pp_d;
            corr_q   <= corr_d;
            s1_vld_q <= E_valid;
            s1_hi_q  <= E_hi;
`ifdef NIOS2_MULT_PIPE_ACC_EN
            s1_acc_q <= E_acc;
            s1_clr_q <= E_acc_clr;
`endif
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < NS; j++)
                sum = sum + (PW'(pp_q[i*NS+j]) << ((i + j) * SLICE_W));
        sum = sum - (PW'(corr_q) << DATA_W);
        s2_d     = '0;
        s2_d.vld = s1_vld_q;
        s2_d.hi  = s1_hi_q;
`ifdef NIOS2_MULT_PIPE_ACC_EN
        s2_d.acc = s1_acc_q;
        s2_d.clr = s1_clr_q;
`endif
        s2_d.p   = sum;
    end

    if (PIPE_STAGES > 2) begin : g_dly
        localparam int ND = PIPE_STAGES - 2;
        stg_t [ND-1:0] dly_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                dly_q <= '0;
            end else if (M_en) begin
                dly_q[0] <= s2_d;
                for (int k = 1; k < ND; k++)
                    dly_q[k] <= dly_q[k-1];
            end
        end

        always_comb begin
            dly_busy = 1'b0;
            for (int k = 0; k < ND; k++)
                dly_busy = dly_busy | dly_q[k].vld;
        end

        assign fin = dly_q[ND-1];
    end else begin : g_nodly
        assign fin      = s2_d;
        assign dly_busy = 1'b0;
    end

    always_comb begin
        fin_p = fin.p;
`ifdef NIOS2_MULT_PIPE_ACC_EN
        acc_d = acc_q;
        if (fin.acc) begin
            acc_d = (fin.clr ? '0 : acc_q) + fin.p;
            fin_p = acc_d;
        end else if (fin.clr) begin
            acc_d = '0;
        end
`endif
    end

    // Output data only moves on a retiring op; bubbles leave the last result visible.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            M_valid   <= 1'b0;
            M_product <= '0;
            M_result  <= '0;
`ifdef NIOS2_MULT_PIPE_ACC_EN
            acc_q     <= '0;
`endif
        end else if (M_en) begin
            M_valid <= fin.vld;
            if (fin.vld) begin
                M_product <= fin_p;
                M_result  <= fin.hi ? fin_p[PW-1:DATA_W] : fin_p[DATA_W-1:0];
`ifdef NIOS2_MULT_PIPE_ACC_EN
                acc_q     <= acc_d;
`endif
            end
        end
    end

    assign busy = s1_vld_q | dly_busy | M_valid;

endmodule

// File: tb/tb_nios2_mult_pipe_cell.sv
// Randomized + directed bench for nios2_mult_pipe_cell: two instances (2-stage/16-bit slices and
// 4-stage/8-bit slices) checked cycle by cycle against a queue-based product model.
module tb_nios2_mult_pipe_cell;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, M_en, E_valid, E_sign1, E_sign2, E_hi, E_acc, E_acc_clr;
    logic [DW-1:0] E_src1, E_src2;
    int            n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                 input logic sa, input logic sb);
        logic [2*DW-1:0] ea, eb;
        ea = {{DW{sa & a[DW-1]}}, a};
        eb = {{DW{sb & b[DW-1]}}, b};
        return ea * eb;
    endfunction

    typedef struct {
        logic [2*DW-1:0] p;
        logic            v, hi, acc, clr;
        int              due;
    } ent_t;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int PS = (g == 0) ? 2 : 4;
        localparam int SW = (g == 0) ? 16 : 8;
        logic            mv, bsy;
        logic [DW-1:0]   res, hr, dut_r;
        logic [2*DW-1:0] prod, hp, dut_p, accm;
        logic            mv_exp;
        ent_t            q[$];
        int              pend = 0, en_cnt = 0, npulse = 0;

        nios2_mult_pipe_cell #(.DATA_W(DW), .SLICE_W(SW), .PIPE_STAGES(PS)) u_dut (
            .clk(clk), .reset_n(reset_n), .M_en(M_en), .E_valid(E_valid),
            .E_src1(E_src1), .E_src2(E_src2), .E_sign1(E_sign1), .E_sign2(E_sign2), .E_hi(E_hi),
`ifdef NIOS2_MULT_PIPE_ACC_EN
            .E_acc(E_acc), .E_acc_clr(E_acc_clr),
`endif
            .M_valid(mv), .M_result(res), .M_product(prod), .busy(bsy)
        );

        always @(posedge clk) begin
            logic            rs, en;
            ent_t            e, c;
            logic [2*DW-1:0] fp;
            rs    = reset_n;
            en    = M_en;
            e.v   = E_valid;
            e.p   = ref_mul(E_src1, E_src2, E_sign1, E_sign2);
            e.hi  = E_hi;
            e.acc = E_acc;
            e.clr = E_acc_clr;
            e.due = en_cnt + PS;
            #1;
            if (!rs) begin
                q.delete();
                en_cnt = 0;
                mv_exp = 1'b0;
                accm   = '0;
                hp     = '0;
                hr     = '0;
            end else if (en) begin
                en_cnt++;
                if (e.v) q.push_back(e);
                mv_exp = (q.size() != 0) && (q[0].due == en_cnt);
                if (mv_exp) begin
                    c  = q.pop_front();
                    fp = c.p;
`ifdef NIOS2_MULT_PIPE_ACC_EN
                    if (c.acc) begin
                        accm = (c.clr ? '0 : accm) + c.p;
                        fp   = accm;
                    end else if (c.clr) begin
                        accm = '0;
                    end
`endif
                    hp = fp;
                    hr = c.hi ? fp[2*DW-1:DW] : fp[DW-1:0];
                end
                if (mv) begin
                    npulse++;
                    dut_p = prod;
                    dut_r = res;
                end
            end
            chk($sformatf("d%0d_valid", g), {63'b0, mv}, {63'b0, mv_exp});
            chk($sformatf("d%0d_product", g), prod, hp);
            chk($sformatf("d%0d_result", g), {32'b0, res}, {32'b0, hr});
            chk($sformatf("d%0d_busy", g), {63'b0, bsy}, {63'b0, (q.size() != 0) || mv_exp});
            pend = q.size();
        end
    end

    task automatic step(input logic v, input logic en, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic s1, input logic s2, input logic hi, input logic ac, input logic cl);
        @(posedge clk);
        #2;
        E_valid = v;   M_en = en;
        E_src1 = a;    E_src2 = b;
        E_sign1 = s1;  E_sign2 = s2;  E_hi = hi;
        E_acc = ac;    E_acc_clr = cl;
    endtask

    task automatic idle();
        step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag);
        idle();
        for (int i = 0; i < 20; i++) begin
            if (g_dut[0].pend == 0 && g_dut[1].pend == 0) break;
            idle();
        end
        chk({tag, "_drain0"}, 64'(g_dut[0].pend), 64'd0);
        chk({tag, "_drain1"}, 64'(g_dut[1].pend), 64'd0);
    endtask

    task automatic dchk(input string tag, input logic [DW-1:0] er, input logic [2*DW-1:0] ep);
        chk({tag, "_r0"}, {32'b0, g_dut[0].dut_r}, {32'b0, er});
        chk({tag, "_p0"}, g_dut[0].dut_p, ep);
        chk({tag, "_r1"}, {32'b0, g_dut[1].dut_r}, {32'b0, er});
        chk({tag, "_p1"}, g_dut[1].dut_p, ep);
    endtask

    function automatic logic [DW-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int p0, p1;
        reset_n = 1'b0; M_en = 1'b0; E_valid = 1'b0; E_src1 = '0; E_src2 = '0;
        E_sign1 = 1'b0; E_sign2 = 1'b0; E_hi = 1'b0; E_acc = 1'b0; E_acc_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        step(1, 1, '1, '1, 0, 0, 0, 0, 0); drain("umax_lo"); dchk("umax_lo", 32'h1, 64'hFFFF_FFFE_0000_0001);
        step(1, 1, '1, '1, 0, 0, 1, 0, 0); drain("umax_hi"); dchk("umax_hi", 32'hFFFF_FFFE, 64'hFFFF_FFFE_0000_0001);
        step(1, 1, '1, '1, 1, 1, 0, 0, 0); drain("ss");      dchk("ss", 32'h1, 64'h1);
        step(1, 1, '1, '1, 1, 0, 1, 0, 0); drain("su");      dchk("su", 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001);
        step(1, 1, 32'h8000_0000, 32'h8000_0000, 1, 1, 1, 0, 0); drain("min_hi");
        dchk("min_hi", 32'h4000_0000, 64'h4000_0000_0000_0000);
        step(1, 1, 32'h8000_0000, 32'h8000_0000, 1, 1, 0, 0, 0); drain("min_lo");
        dchk("min_lo", 32'h0, 64'h4000_0000_0000_0000);

        // Stall mid-stream with junk on E_* that must be ignored.
        p0 = g_dut[0].npulse; p1 = g_dut[1].npulse;
        step(1, 1, 3, 4, 0, 0, 0, 0, 0);
        step(1, 1, 5, 6, 0, 0, 0, 0, 0);
        step(1, 0, 9, 9, 0, 0, 0, 0, 0);
        step(1, 0, 9, 9, 0, 0, 0, 0, 0);
        step(1, 1, 7, 8, 0, 0, 0, 0, 0);
        drain("stall");
        chk("stall_pulses0", 64'(g_dut[0].npulse - p0), 64'd3);
        chk("stall_pulses1", 64'(g_dut[1].npulse - p1), 64'd3);
        dchk("stall_last", 32'd56, 64'd56);

        step(1, 1, 11, 13, 0, 0, 0, 0, 0);
        step(1, 1, 17, 19, 0, 0, 0, 0, 0);
        @(posedge clk); #2 reset_n = 1'b0; E_valid = 1'b0;
        @(posedge clk); #2 reset_n = 1'b1;
        step(1, 1, 2, 2, 0, 0, 0, 0, 0); drain("post_rst"); dchk("post_rst", 32'd4, 64'd4);

`ifdef NIOS2_MULT_PIPE_ACC_EN
        step(1, 1, 3, 4, 0, 0, 0, 1, 1); drain("acc1"); dchk("acc1", 32'd12, 64'd12);
        step(1, 1, 5, 6, 0, 0, 0, 1, 0); drain("acc2"); dchk("acc2", 32'd42, 64'd42);
        step(1, 1, 1, 1, 0, 0, 0, 0, 0); drain("acc3"); dchk("acc3", 32'd1, 64'd1);
        step(1, 1, 0, 0, 0, 0, 0, 1, 0); drain("acc4"); dchk("acc4", 32'd42, 64'd42);
`endif

        for (int i = 0; i < 400; i++) begin
            logic ac, cl;
`ifdef NIOS2_MULT_PIPE_ACC_EN
            ac = 1'($urandom_range(0, 1));
            cl = ($urandom_range(0, 3) == 0);
`else
            ac = 1'b0;
            cl = 1'b0;
`endif
            step($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, pick(), pick(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ac, cl);
        end
        drain("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
